// File: rtl/pump_controller_fsm.sv
// -----------------------------------------------------------------------------
// pump_controller_fsm
//
// Purpose: automatic transfer-pump controller between a lower (inf) and an
// upper (sup) tank. Raw level codes are normalised (optionally inverted for
// active-low sensors) and then debounced. A four-state FSM drives the pump
// from the debounced levels only:
//   IDLE -> PUMPING -> LOCKOUT -> IDLE, with FAULT on out-of-range levels.
// LOCKOUT is an anti-short-cycle hold-off of MIN_OFF_CYCLES cycles.
//
// Optional feature: define PUMP_RUN_TIMEOUT_EN to add a no-progress watchdog
// while PUMPING. The watchdog counter clears whenever the debounced upper level
// rises; reaching RUN_TIMEOUT_CYCLES sends the FSM to FAULT. Without the macro
// no watchdog logic exists and the timeout term is a constant 0.
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   lvl_inf       in   raw lower-tank level code  [LVL_W-1:0]
//   lvl_sup       in   raw upper-tank level code  [LVL_W-1:0]
//   en_auto       in   automatic mode enable
//   fault_clr     in   fault acknowledge
//   pump_on       out  pump drive (state == PUMPING)
//   solenoid_open out  refill valve (lower level below refill mark, no fault)
//   led_green     out  mirrors pump_on
//   led_red       out  inverse of pump_on
//   fault         out  state == FAULT
//   state_o       out  current FSM state encoding [1:0]
// -----------------------------------------------------------------------------
module pump_controller_fsm #(
    parameter int CLK_HZ             = 25_000_000,
    parameter int LVL_W              = 3,
    parameter int LVL_MAX            = 4,
    parameter int INVERT_LEVEL_CODE  = 0,
    parameter int LVL_SUP_START      = 1,
    parameter int LVL_INF_START      = 3,
    parameter int LVL_SUP_STOP       = 3,
    parameter int LVL_INF_STOP       = 1,
    parameter int LVL_INF_REFILL     = 4,
    parameter int DEB_CYCLES         = 4,
    parameter int MIN_OFF_CYCLES     = 8,
    parameter int RUN_TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LVL_W-1:0] lvl_inf,
    input  logic [LVL_W-1:0] lvl_sup,
    input  logic             en_auto,
    input  logic             fault_clr,
    output logic             pump_on,
    output logic             solenoid_open,
    output logic             led_green,
    output logic             led_red,
    output logic             fault,
    output logic [1:0]       state_o
);

    // CLK_HZ only documents the clock; RUN_TIMEOUT_CYCLES is only consumed
    // when the watchdog is built. Neither needs hardware here.
    if (CLK_HZ < 1 || RUN_TIMEOUT_CYCLES < 1) begin : g_cfg_doc
    end

    // Both lengths are defined with a minimum of 1.
    localparam int DEB_N  = (DEB_CYCLES < 1) ? 1 : DEB_CYCLES;
    localparam int OFF_N  = (MIN_OFF_CYCLES < 1) ? 1 : MIN_OFF_CYCLES;
    localparam int DEB_CW = $clog2(DEB_N + 1);
    localparam int OFF_CW = $clog2(OFF_N + 1);

    localparam logic [DEB_CW-1:0] DEB_TOP = DEB_CW'(DEB_N);
    localparam logic [OFF_CW-1:0] OFF_TOP = OFF_CW'(OFF_N);

    localparam logic [LVL_W-1:0] L_MAX        = LVL_W'(LVL_MAX);
    localparam logic [LVL_W-1:0] L_SUP_START  = LVL_W'(LVL_SUP_START);
    localparam logic [LVL_W-1:0] L_INF_START  = LVL_W'(LVL_INF_START);
    localparam logic [LVL_W-1:0] L_SUP_STOP   = LVL_W'(LVL_SUP_STOP);
    localparam logic [LVL_W-1:0] L_INF_STOP   = LVL_W'(LVL_INF_STOP);
    localparam logic [LVL_W-1:0] L_INF_REFILL = LVL_W'(LVL_INF_REFILL);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PUMPING = 2'd1,
        S_LOCKOUT = 2'd2,
        S_FAULT   = 2'd3
    } state_e;

    // -------------------------------------------------------------------------
    // Normalisation and debounce. Channel 0 = lower tank, channel 1 = upper.
    // -------------------------------------------------------------------------
    function automatic logic [LVL_W-1:0] normalise(input logic [LVL_W-1:0] raw);
        if (INVERT_LEVEL_CODE != 0) begin
            return L_MAX - raw;
        end
        return raw;
    endfunction

    logic [1:0][LVL_W-1:0]  norm;
    logic [1:0][LVL_W-1:0]  samp_q;
    logic [1:0][LVL_W-1:0]  lvl_q;
    logic [1:0][DEB_CW-1:0] cnt_q;
    logic [1:0][DEB_CW-1:0] cnt_d;
    logic [LVL_W-1:0]       inf_lvl;
    logic [LVL_W-1:0]       sup_lvl;

    assign norm[0] = normalise(lvl_inf);
    assign norm[1] = normalise(lvl_sup);

    // cnt_q counts consecutive identical samples including the current one.
    // A zero count (after reset) means no valid previous sample exists, so the
    // full DEB_CYCLES run is needed before anything is accepted.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (cnt_q[i] == '0 || norm[i] != samp_q[i]) begin
                cnt_d[i] = DEB_CW'(1);
            end else if (cnt_q[i] == DEB_TOP) begin
                cnt_d[i] = DEB_TOP;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q <= '0;
            cnt_q  <= '0;
            lvl_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            samp_q <= norm;
            cnt_q  <= cnt_d;
            for (int i = 0; i < 2; i++) begin
                if (cnt_d[i] == DEB_TOP) begin
                    lvl_q[i] <= norm[i];
                end
            end
        end
    end

    assign inf_lvl = lvl_q[0];
    assign sup_lvl = lvl_q[1];

    // -------------------------------------------------------------------------
    // Level decisions (debounced values only)
    // -------------------------------------------------------------------------
    logic start;
    logic stop;
    logic range_err;
    logic timeout;

    assign start     = (sup_lvl == L_SUP_START) && (inf_lvl == L_INF_START);
    assign stop      = (inf_lvl <= L_INF_STOP) || (sup_lvl >= L_SUP_STOP);
    assign range_err = (inf_lvl > L_MAX) || (sup_lvl > L_MAX);

    state_e state_q;
    state_e state_d;

`ifdef PUMP_RUN_TIMEOUT_EN
    // -------------------------------------------------------------------------
    // No-progress watchdog: zero outside PUMPING (so it is clear on entry),
    // cleared when the upper level rises, saturating at RUN_TIMEOUT_CYCLES.
    // -------------------------------------------------------------------------
    localparam int RUN_CW = $clog2(RUN_TIMEOUT_CYCLES + 1);
    localparam logic [RUN_CW-1:0] RUN_TOP = RUN_CW'(RUN_TIMEOUT_CYCLES);

    logic [RUN_CW-1:0] run_cnt_q;
    logic [RUN_CW-1:0] run_cnt_d;
    logic [LVL_W-1:0]  sup_prev_q;

    always_comb begin
        run_cnt_d = '0;
        if (state_q == S_PUMPING && !(sup_lvl > sup_prev_q)) begin
            run_cnt_d = (run_cnt_q == RUN_TOP) ? RUN_TOP : run_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt_q  <= '0;
            sup_prev_q <= '0;
        end else begin
            run_cnt_q  <= run_cnt_d;
            sup_prev_q <= sup_lvl;
        end
    end

    assign timeout = (run_cnt_q == RUN_TOP);
`else
    assign timeout = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    logic [OFF_CW-1:0] off_cnt_q;
    logic [OFF_CW-1:0] off_cnt_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (range_err) begin
                    state_d = S_FAULT;
                end else if (en_auto && start) begin
                    state_d = S_PUMPING;
                end
            end
            S_PUMPING: begin
                if (range_err || timeout) begin
                    state_d = S_FAULT;
                end else if (!en_auto || stop) begin
                    state_d = S_LOCKOUT;
                end
            end
            S_LOCKOUT: begin
                // Leave on the edge where the counter steps from 1 to 0, so
                // LOCKOUT lasts exactly MIN_OFF_CYCLES cycles.
                if (range_err) begin
                    state_d = S_FAULT;
                end else if (off_cnt_q <= OFF_CW'(1)) begin
                    state_d = S_IDLE;
                end
            end
            S_FAULT: begin
                if (fault_clr && !range_err) begin
                    state_d = S_LOCKOUT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Lockout counter: loaded on any entry into LOCKOUT, counts down while in
    // it, saturating at zero.
    always_comb begin
        off_cnt_d = '0;
        if (state_d == S_LOCKOUT && state_q != S_LOCKOUT) begin
            off_cnt_d = OFF_TOP;
        end else if (state_q == S_LOCKOUT && off_cnt_q != '0) begin
            off_cnt_d = off_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            off_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            off_cnt_q <= off_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: pure decodes of registered state, so reset acts on them
    // immediately.
    // -------------------------------------------------------------------------
    assign pump_on       = (state_q == S_PUMPING);
    assign led_green     = pump_on;
    assign led_red       = ~pump_on;
    assign fault         = (state_q == S_FAULT);
    assign solenoid_open = (inf_lvl < L_INF_REFILL) && (state_q != S_FAULT);
    assign state_o       = state_q;

endmodule

// File: tb/tb_pump_controller_fsm.sv
// -----------------------------------------------------------------------------
// tb_pump_controller_fsm
//
// Self-checking bench for pump_controller_fsm with default parameters.
// Expected output vectors {pump_on, solenoid_open, led_green, led_red, fault,
// state_o} are pushed to a scoreboard queue as stimulus is applied and popped
// and compared once the DUT has had the cycles to respond. Inputs are driven
// and outputs sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_pump_controller_fsm;

    localparam int LVL_W       = 3;
    localparam int DEB         = 4;
    localparam int MIN_OFF     = 8;
    localparam int RUN_TIMEOUT = 64;

    // {pump_on, solenoid_open, led_green, led_red, fault, state_o[1:0]}
    localparam logic [6:0] O_IDLE     = 7'b0101_0_00;
    localparam logic [6:0] O_IDLE_DRY = 7'b0001_0_00; // lower level >= refill
    localparam logic [6:0] O_PUMP     = 7'b1110_0_01;
    localparam logic [6:0] O_LOCK     = 7'b0101_0_10;
    localparam logic [6:0] O_FAULT    = 7'b0001_1_11;

    typedef struct {
        string      name;
        logic [6:0] exp;
    } sb_t;

    logic             clk;
    logic             rst_n;
    logic [LVL_W-1:0] lvl_inf;
    logic [LVL_W-1:0] lvl_sup;
    logic             en_auto;
    logic             fault_clr;
    logic             pump_on;
    logic             solenoid_open;
    logic             led_green;
    logic             led_red;
    logic             fault;
    logic [1:0]       state_o;

    sb_t sb_q[$];
    int  total = 0;
    int  bad   = 0;

    pump_controller_fsm #(
        .LVL_W              (LVL_W),
        .DEB_CYCLES         (DEB),
        .MIN_OFF_CYCLES     (MIN_OFF),
        .RUN_TIMEOUT_CYCLES (RUN_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lvl_inf       (lvl_inf),
        .lvl_sup       (lvl_sup),
        .en_auto       (en_auto),
        .fault_clr     (fault_clr),
        .pump_on       (pump_on),
        .solenoid_open (solenoid_open),
        .led_green     (led_green),
        .led_red       (led_red),
        .fault         (fault),
        .state_o       (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] obs();
        return {pump_on, solenoid_open, led_green, led_red, fault, state_o};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        en_auto   = 1'b0;
        fault_clr = 1'b0;
        lvl_inf   = '0;
        lvl_sup   = '0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        sb_t e;
        rst_n     = 1'b0;
        en_auto   = 1'b0;
        fault_clr = 1'b0;
        lvl_inf   = '0;
        lvl_sup   = '0;
        sb_q.push_back('{"reset_outputs", O_IDLE});
        #2;
        e = sb_q.pop_front();
        total++;
        if (obs() !== e.exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.exp);
        end
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic test_start_stop();
        sb_t e;
        do_reset();
        en_auto = 1'b1;
        lvl_inf = 3'd3;
        lvl_sup = 3'd1;
        sb_q.push_back('{"ss_idle_after_4", O_IDLE});
        step(DEB);
        e = sb_q.pop_front();
        total++;
        if (obs() !== e.exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.exp);
        end
        sb_q.push_back('{"ss_pump_on_5th_edge", O_PUMP});
        step(1);
        e = sb_q.pop_front();
        total++;
        if (obs() !== e.exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.exp);
        end
        lvl_sup = 3'd3;
        sb_q.push_back('{"ss_still_pumping", O_PUMP});
        step(DEB);
        e = sb_q.pop_front();
        total++;
        if (obs() !== e.exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.exp);
        end
        sb_q.push_back('{"ss_lockout", O_LOCK});
        step(1);
        e = sb_q.pop_front();
        total++;
        if (obs() !== e.exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.exp);
        end
        sb_q.push_back('{"ss_lockout_last", O_LOCK});
        step(MIN_OFF - 1);
        e = sb_q.pop_front();
        total++;
        if (obs() !== e.exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.exp);
        end
        sb_q.push_back('{"ss_idle_after_lockout", O_IDLE});
        step(1);
        e = sb_q.pop_front();
        total++;
        if (obs() !== e.exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.exp);
        end
    endtask

    // Upper level toggles 1/2 every two cycles: never stable for DEB cycles,
    // so the pump must never start. Then it settles at 1 and the pump starts.
    task automatic test_debounce();
        sb_t e;
        do_reset();
        en_auto = 1'b1;
        lvl_inf = 3'd3;
        for (int i = 0; i < 24; i++) begin
            lvl_sup = (((i / 2) % 2) != 0) ? 3'd2 : 3'd1;
            sb_q.push_back('{"deb_toggle_idle", O_IDLE});
            step(1);
            e = sb_q.pop_front();
            total++;
            if (obs() !== e.exp) begin
                bad++;
                $display("FAIL %s: cycle %0d got %b expected %b", e.name, i, obs(), e.exp);
            end
        end
        lvl_sup = 3'd1;
        sb_q.push_back('{"deb_settle_idle", O_IDLE});
        step(DEB);
        e = sb_q.pop_front();
        total++;
        if (obs() !== e.exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.exp);
        end
        sb_q.push_back('{"deb_settle_pump", O_PUMP});
        step(1);
        e = sb_q.pop_front();
        total++;
        if (obs() !== e.exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.exp);
        end
    endtask

    // Entered while pumping with start held: drop en_auto for one cycle to
    // stop, then restore it. Start must be ignored for the whole lockout.
    task automatic test_lockout();
        sb_t e;
        en_auto = 1'b0;
        sb_q.push_back('{"lo_enter", O_LOCK});
        step(1);
        e = sb_q.pop_front();
        total++;
        if (obs() !== e.exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.exp);
        end
        en_auto = 1'b1;
        for (int i = 1; i < MIN_OFF; i++) begin
            sb_q.push_back('{"lo_hold", O_LOCK});
            step(1);
            e = sb_q.pop_front();
            total++;
            if (obs() !== e.exp) begin
                bad++;
                $display("FAIL %s: cycle %0d got %b expected %b", e.name, i, obs(), e.exp);
            end
        end
        sb_q.push_back('{"lo_idle", O_IDLE});
        step(1);
        e = sb_q.pop_front();
        total++;
        if (obs() !== e.exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.exp);
        end
        sb_q.push_back('{"lo_repump", O_PUMP});
        step(1);
        e = sb_q.pop_front();
        total++;
        if (obs() !== e.exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.exp);
        end
    endtask

    task automatic test_range_fault();
        sb_t e;
        do_reset();
        en_auto = 1'b1;
        lvl_inf = 3'd7;
        lvl_sup = 3'd1;
        sb_q.push_back('{"rf_idle_dry", O_IDLE_DRY});
        step(DEB);
        e = sb_q.pop_front();
        total++;
        if (obs() !== e.exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.exp);
        end
        sb_q.push_back('{"rf_fault", O_FAULT});
        step(1);
        e = sb_q.pop_front();
        total++;
        if (obs() !== e.exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.exp);
        end
        fault_clr = 1'b1;
        sb_q.push_back('{"rf_clr_ignored", O_FAULT});
        step(3);
        e = sb_q.pop_front();
        total++;
        if (obs() !== e.exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.exp);
        end
        fault_clr = 1'b0;
        lvl_inf   = 3'd3;
        sb_q.push_back('{"rf_hold_no_clr", O_FAULT});
        step(DEB);
        e = sb_q.pop_front();
        total++;
        if (obs() !== e.exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.exp);
        end
        fault_clr = 1'b1;
        sb_q.push_back('{"rf_to_lockout", O_LOCK});
        step(1);
        e = sb_q.pop_front();
        total++;
        if (obs() !== e.exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.exp);
        end
        fault_clr = 1'b0;
        sb_q.push_back('{"rf_lockout_to_idle", O_IDLE});
        step(MIN_OFF);
        e = sb_q.pop_front();
        total++;
        if (obs() !== e.exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.exp);
        end
    endtask

    task automatic test_timeout();
        sb_t e;
        do_reset();
        en_auto = 1'b1;
        lvl_inf = 3'd3;
        lvl_sup = 3'd1;
        sb_q.push_back('{"to_pumping", O_PUMP});
        step(DEB + 1);
        e = sb_q.pop_front();
        total++;
        if (obs() !== e.exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.exp);
        end
`ifdef PUMP_RUN_TIMEOUT_EN
        begin
            int n;
            n = 0;
            // The counter is 0 in the first PUMPING cycle and reaches
            // RUN_TIMEOUT after that many edges; the FSM moves on the next.
            while (!fault && n < 4 * RUN_TIMEOUT) begin
                step(1);
                n++;
            end
            total++;
            if (n !== RUN_TIMEOUT + 1) begin
                bad++;
                $display("FAIL to_cycles: got %0d expected %0d", n, RUN_TIMEOUT + 1);
            end
            sb_q.push_back('{"to_fault", O_FAULT});
            e = sb_q.pop_front();
            total++;
            if (obs() !== e.exp) begin
                bad++;
                $display("FAIL %s: got %b expected %b", e.name, obs(), e.exp);
            end
        end
`else
        sb_q.push_back('{"to_persist", O_PUMP});
        step(RUN_TIMEOUT + 36);
        e = sb_q.pop_front();
        total++;
        if (obs() !== e.exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.exp);
        end
`endif
    endtask

    task automatic test_async_reset();
        sb_t e;
        do_reset();
        en_auto = 1'b1;
        lvl_inf = 3'd3;
        lvl_sup = 3'd1;
        sb_q.push_back('{"ar_pumping", O_PUMP});
        step(DEB + 1);
        e = sb_q.pop_front();
        total++;
        if (obs() !== e.exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.exp);
        end
        #3;
        rst_n = 1'b0;
        sb_q.push_back('{"ar_async_drop", O_IDLE});
        #2;
        e = sb_q.pop_front();
        total++;
        if (obs() !== e.exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.exp);
        end
        step(1);
        rst_n = 1'b1;
        sb_q.push_back('{"ar_full_debounce", O_IDLE});
        step(DEB);
        e = sb_q.pop_front();
        total++;
        if (obs() !== e.exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.exp);
        end
        sb_q.push_back('{"ar_resume_pump", O_PUMP});
        step(1);
        e = sb_q.pop_front();
        total++;
        if (obs() !== e.exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", e.name, obs(), e.exp);
        end
    endtask

    initial begin
        test_reset();
        test_start_stop();
        test_debounce();
        test_lockout();
        test_range_fault();
        test_timeout();
        test_async_reset();
        total++;
        if (sb_q.size() !== 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/pump_controller_fsm.md
PUMP_CONTROLLER_FSM -- requirements
Module: pump_controller_fsm

Interface
REQ-001 SHALL provide parameter CLK_HZ, default 25_000_000, system clock frequency (documentation only).
REQ-002 SHALL provide parameter LVL_W, default 3, width of each level code.
REQ-003 SHALL provide parameter LVL_MAX, default 4, highest valid level code (100%).
REQ-004 SHALL provide parameter INVERT_LEVEL_CODE, default 0: if 1, the normalised level is LVL_MAX minus the raw code, for active-low sensors.
REQ-005 SHALL provide parameters LVL_SUP_START=1, LVL_INF_START=3, LVL_SUP_STOP=3, LVL_INF_STOP=1, LVL_INF_REFILL=4 (normalised codes).
REQ-006 SHALL provide parameter DEB_CYCLES, default 4, the number of consecutive stable cycles needed to accept a level (minimum 1).
REQ-007 SHALL provide parameter MIN_OFF_CYCLES, default 8, the lockout length after the pump stops (minimum 1).
REQ-008 SHALL provide parameter RUN_TIMEOUT_CYCLES, default 64, the no-progress limit while pumping.
REQ-009 SHALL have ports: clk in 1 system clock; rst_n in 1 asynchronous active-low reset; lvl_inf in LVL_W raw lower-tank code; lvl_sup in LVL_W raw upper-tank code; en_auto in 1 automatic enable; fault_clr in 1 fault acknowledge; pump_on out 1; solenoid_open out 1; led_green out 1; led_red out 1; fault out 1; state_o out 2 FSM state encoding.

Function
REQ-010 Each raw input SHALL be normalised, then debounced.
  - The debounced value updates when the normalised value has been identical for DEB_CYCLES consecutive cycles.
  - Any change restarts the count.
REQ-011 All decisions SHALL use debounced levels only (inf_d, sup_d).
REQ-012 Compare semantics:
  - start = sup_d==LVL_SUP_START && inf_d==LVL_INF_START.
  - stop = inf_d<=LVL_INF_STOP || sup_d>=LVL_SUP_STOP.
  - range_err = inf_d>LVL_MAX || sup_d>LVL_MAX.
REQ-013 The FSM SHALL have four states: IDLE=0, PUMPING=1, LOCKOUT=2, FAULT=3; state_o equals the current state.
REQ-014 IDLE SHALL transition as follows:
  - range_err -> FAULT.
  - else en_auto && start -> PUMPING.
  - else hold.
REQ-015 PUMPING SHALL transition with priority range_err -> FAULT, timeout -> FAULT, !en_auto || stop -> LOCKOUT; otherwise hold.
REQ-016 LOCKOUT SHALL load a counter with MIN_OFF_CYCLES on entry and decrement it each cycle.
  - Exit to IDLE on the cycle the counter reaches 0.
  - range_err -> FAULT with priority.
  - start is ignored during LOCKOUT (anti short-cycle).
REQ-017 FAULT SHALL transition to LOCKOUT when fault_clr==1 and range_err==0; otherwise hold. en_auto does not exit FAULT.
REQ-018 Outputs SHALL be registered-state decodes with zero added latency from state:
  - pump_on=(state==PUMPING).
  - led_green=pump_on.
  - led_red=~pump_on.
  - fault=(state==FAULT).
REQ-019 solenoid_open SHALL be 1 when inf_d<LVL_INF_REFILL and state!=FAULT, and 0 otherwise.
REQ-020 Counter widths SHALL be $clog2(param+1); counters SHALL saturate and never wrap.
REQ-021 If start and stop are true in the same cycle in IDLE, the FSM SHALL enter PUMPING and leave on the next cycle via stop (documented misconfiguration).

Reset
REQ-022 When rst_n is low, state SHALL be IDLE asynchronously, with all counters 0 and inf_d=sup_d=0.
REQ-023 During reset, outputs SHALL be pump_on=0, led_green=0, led_red=1, fault=0, solenoid_open=1 (inf_d=0<REFILL), state_o=0.
REQ-024 Reset asserted mid-PUMPING SHALL force pump_on=0 without waiting for a clock edge; the FSM SHALL resume in IDLE on release.
REQ-025 After reset release, debounce SHALL require the full DEB_CYCLES before any level is accepted.

Configuration
REQ-026 Macro PUMP_RUN_TIMEOUT_EN SHALL select the run-timeout behaviour as follows:
  - Defined: a counter clears on PUMPING entry and whenever sup_d increases, and increments each PUMPING cycle. timeout=1 when the counter reaches RUN_TIMEOUT_CYCLES.
  - Undefined: no counter logic is synthesised, timeout is constant 0, and PUMPING exits only via range_err, !en_auto or stop.

Verification
REQ-027 Start/stop sequence SHALL be covered:
  - Stimulus: reset, en_auto=1, lvl_inf=3, lvl_sup=1 held 4 cycles.
  - Response: pump_on=1 on the 5th edge; then lvl_sup=3 gives LOCKOUT, then IDLE after 8 cycles.
REQ-028 Debounce SHALL be covered: lvl_sup toggling 1/2 every 2 cycles -> sup_d never changes and pump_on stays 0.
REQ-029 Lockout SHALL be covered: start condition held through LOCKOUT -> pump_on stays 0 for exactly MIN_OFF_CYCLES, then PUMPING again one cycle after reaching IDLE.
REQ-030 Range fault SHALL be covered:
  - Stimulus: lvl_inf=7 stable 4 cycles.
  - Response: fault=1, solenoid_open=0, pump_on=0.
  - fault_clr with lvl_inf=7 does not clear the fault; with lvl_inf=3 and fault_clr=1, the FSM goes to LOCKOUT.
REQ-031 Timeout (macro defined) SHALL be covered: PUMPING with lvl_sup frozen at 1 -> FAULT after 64 cycles. With the macro undefined, PUMPING persists.
REQ-032 Asynchronous reset SHALL be covered: rst_n dropped mid-cycle in PUMPING -> pump_on falls before the next posedge, and state_o=0.
